prog_counter: RTL and testbench
===============================

// Module: prog_counter
//
// PURPOSE
//   Fetch-stage program counter that drives the 10-bit Address port of the
//   instruction memory. It sequences through the program: increment, absolute
//   jump, PC-relative branch, stall hold and halt. A Start/Done handshake
//   connects it to the testbench/top level. The count of fetched instructions
//   is exported for debug.
//
// PARAMETERS
//   AW         10  address width; must match instruction-memory depth 2^AW
//   OFFW        6  width of signed relative-branch offset (two's complement)
//   START_ADDR  0  Address value held while in reset/IDLE
//   CW         16  width of InstCount
//
// PORTS
//   Clk        in   1     rising-edge clock
//   Reset      in   1     synchronous, active-low reset
//   Start      in   1     1-cycle pulse: begin execution at StartAddr
//   StartAddr  in   AW    first instruction address, sampled with Start
//   Stall      in   1     hold current Address this cycle
//   BranchAbs  in   1     load Target into Address
//   BranchRel  in   1     add sign-extended Offset to Address
//   Target     in   AW    absolute jump target
//   Offset     in   OFFW  signed relative offset
//   HaltReq    in   1     decoded halt instruction at current Address
//   Address    out  AW    registered PC -> instruction memory Address
//   Running    out  1     1 while in RUN
//   Done       out  1     1 while in HALTED (level, not pulse)
//   InstCount  out  CW    instructions advanced past since last Start
//
// BEHAVIOUR
//   - All outputs are registered; every control input is sampled on the rising
//     edge of Clk. The memory read is combinational, so Instruction is valid in
//     the same cycle as Address.
//   - Reset=0 at an edge forces: state=IDLE, Address=START_ADDR, Running=0,
//     Done=0, InstCount=0. This overrides every other input, including
//     mid-RUN or HALTED.
//   - FSM states: IDLE, RUN, HALTED. Running = (state==RUN);
//     Done = (state==HALTED).
//   - IDLE
//     - Start=1: Address<=StartAddr, InstCount<=0, go to RUN.
//     - Otherwise hold.
//   - RUN: per edge, the first true condition in this order applies:
//     1. HaltReq   -> HALTED; Address holds; InstCount holds.
//     2. Stall     -> Address holds; InstCount holds.
//     3. BranchAbs -> Address<=Target.
//     4. BranchRel -> Address<=(Address + sext(Offset)) mod 2^AW.
//     5. else      -> Address<=(Address + 1) mod 2^AW; 1023 wraps to 0.
//     - Cases 3-5 increment InstCount. InstCount saturates at 2^CW-1.
//     - Start is ignored in RUN.
//     - BranchAbs and BranchRel both high: BranchAbs wins.
//     - HaltReq plus a branch: halt wins; no redirect.
//   - HALTED
//     - Address and InstCount freeze.
//     - Start=1: Address<=StartAddr, InstCount<=0, go to RUN. Done falls and
//       Running rises on the same edge.
//   - Relative arithmetic is AW-bit modular. Negative offsets below 0 wrap
//     to the top of memory.
//
// TESTING
//   - Reset=0 for 2 cycles with Start=1 -> Address=0, Running=0, Done=0,
//     InstCount=0.
//   - Start with StartAddr=5, no other controls, run 4 cycles -> Address
//     5,6,7,8,9; InstCount=4.
//   - Address=1023, free-running -> next Address=0. Address=2 with BranchRel,
//     Offset=-3 -> Address=1023.
//   - In RUN, assert BranchAbs with Target=100 and BranchRel with Offset=+4
//     together -> Address=100. Stall for 3 cycles -> Address and InstCount
//     unchanged.
//   - HaltReq at Address=12 -> Done=1 next cycle and Address stays 12 after
//     further edges. Start with StartAddr=0 -> Running=1, Address=0,
//     InstCount=0.
//   - Reset=0 mid-RUN at Address=40 -> next edge gives IDLE, Address=0,
//     InstCount=0.

Source files
------------

// File: rtl/prog_counter.sv
// -----------------------------------------------------------------------------
// prog_counter
//   Fetch-stage program counter. It drives the address port of the
//   instruction memory and steps through the program: increment, absolute
//   jump, PC-relative branch, stall hold and halt. A start/done handshake
//   connects it to the top level. It also exports the number of instructions
//   fetched since the last start, for debug.
//
// Parameters
//   AW          address width (instruction memory depth is 2^AW)
//   OFFW        width of the signed relative-branch offset
//   START_ADDR  address held while in reset / IDLE
//   CW          width of inst_count
//
// Ports
//   clk         in   1     rising-edge clock
//   reset       in   1     synchronous, active-low reset
//   start       in   1     pulse: begin execution at start_addr
//   start_addr  in   AW    first instruction address, sampled with start
//   stall       in   1     hold the current address this cycle
//   branch_abs  in   1     load target into address
//   branch_rel  in   1     add sign-extended offset to address
//   target      in   AW    absolute jump target
//   offset      in   OFFW  signed relative offset
//   halt_req    in   1     decoded halt instruction at the current address
//   address     out  AW    registered PC, goes to instruction memory
//   running     out  1     high while in RUN
//   done        out  1     high while in HALTED (level)
//   inst_count  out  CW    instructions advanced past since last start
// -----------------------------------------------------------------------------
module prog_counter #(
  parameter int unsigned    AW         = 10,
  parameter int unsigned    OFFW       = 6,
  parameter logic [AW-1:0]  START_ADDR = '0,
  parameter int unsigned    CW         = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [AW-1:0]   start_addr,
  input  logic            stall,
  input  logic            branch_abs,
  input  logic            branch_rel,
  input  logic [AW-1:0]   target,
  input  logic [OFFW-1:0] offset,
  input  logic            halt_req,
  output logic [AW-1:0]   address,
  output logic            running,
  output logic            done,
  output logic [CW-1:0]   inst_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [AW-1:0]   address_next;
  logic [CW-1:0]   inst_count_next;
  logic [AW-1:0]   offset_sext;
  logic [CW-1:0]   inst_count_inc;

  // Sign-extend the offset to address width; the add below then wraps
  // modulo 2^AW, so a negative step past 0 lands at the top of memory.
  assign offset_sext = {{(AW-OFFW){offset[OFFW-1]}}, offset};

  // Saturating increment: the count sticks at all-ones.
  assign inst_count_inc = (inst_count == {CW{1'b1}}) ? inst_count
                                                      : inst_count + 1'b1;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      address    <= START_ADDR;
      inst_count <= '0;
      running    <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      address    <= address_next;
      inst_count <= inst_count_next;
      running    <= (state_next == RUN);
      done       <= (state_next == HALTED);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start)    state_next = RUN;
      RUN:     if (halt_req) state_next = HALTED;
      HALTED:  if (start)    state_next = RUN;
      default:               state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next values (address / instruction count)
  // ---------------------------------------------------------------------------
  always_comb begin
    address_next    = address;
    inst_count_next = inst_count;
    unique case (state)
      IDLE, HALTED: begin
        if (start) begin
          address_next    = start_addr;
          inst_count_next = '0;
        end
      end
      RUN: begin
        // Priority: halt, stall, absolute jump, relative branch, increment.
        // Start is ignored here.
        if (halt_req || stall) begin
          address_next = address;
        end else begin
          if (branch_abs)      address_next = target;
          else if (branch_rel) address_next = address + offset_sext;
          else                 address_next = address + 1'b1;
          inst_count_next = inst_count_inc;
        end
      end
      default: begin
        address_next    = START_ADDR;
        inst_count_next = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_prog_counter.sv
module tb_prog_counter;

  localparam int AW   = 10;
  localparam int OFFW = 6;
  localparam int CW   = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [AW-1:0]   start_addr;
  logic            stall;
  logic            branch_abs;
  logic            branch_rel;
  logic [AW-1:0]   target;
  logic [OFFW-1:0] offset;
  logic            halt_req;
  logic [AW-1:0]   address;
  logic            running;
  logic            done;
  logic [CW-1:0]   inst_count;

  int checks = 0;
  int errors = 0;

  prog_counter #(.AW(AW), .OFFW(OFFW), .START_ADDR('0), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .stall      (stall),
    .branch_abs (branch_abs),
    .branch_rel (branch_rel),
    .target     (target),
    .offset     (offset),
    .halt_req   (halt_req),
    .address    (address),
    .running    (running),
    .done       (done),
    .inst_count (inst_count)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle 1 time unit before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_state(input string tag, input int exp_addr,
                             input int exp_cnt, input bit exp_run,
                             input bit exp_done);
    check({tag, " address"}, 32'(address), 32'(exp_addr));
    check({tag, " inst_count"}, 32'(inst_count), 32'(exp_cnt));
    check({tag, " running"}, 32'(running), 32'(exp_run));
    check({tag, " done"}, 32'(done), 32'(exp_done));
  endtask

  task automatic clear_ctrl();
    start      = 1'b0;
    stall      = 1'b0;
    branch_abs = 1'b0;
    branch_rel = 1'b0;
    halt_req   = 1'b0;
    target     = '0;
    offset     = '0;
  endtask

  initial begin
    clear_ctrl();
    start_addr = '0;

    // Reset held low for 2 cycles while start is asserted: reset wins.
    reset = 1'b0;
    start = 1'b1;
    start_addr = 10'd77;
    step();
    step();
    check_state("reset", 0, 0, 1'b0, 1'b0);

    // Start at 5, then free-run four cycles.
    reset = 1'b1;
    start_addr = 10'd5;
    step();
    check_state("start5", 5, 0, 1'b1, 1'b0);
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check_state($sformatf("inc%0d", i), 5 + i, i, 1'b1, 1'b0);
    end

    // Start is ignored while running.
    start = 1'b1;
    start_addr = 10'd300;
    step();
    check_state("start_in_run", 10, 5, 1'b1, 1'b0);
    start = 1'b0;

    // Wrap from the top of memory.
    branch_abs = 1'b1;
    target = 10'd1023;
    step();
    check_state("jump1023", 1023, 6, 1'b1, 1'b0);
    clear_ctrl();
    step();
    check_state("wrap0", 0, 7, 1'b1, 1'b0);

    // Negative relative branch below 0 wraps upward.
    branch_abs = 1'b1;
    target = 10'd2;
    step();
    check_state("jump2", 2, 8, 1'b1, 1'b0);
    clear_ctrl();
    branch_rel = 1'b1;
    offset = 6'b111101;  // -3
    step();
    check_state("rel_m3", 1023, 9, 1'b1, 1'b0);

    // Both branches high: absolute wins.
    branch_abs = 1'b1;
    target = 10'd100;
    branch_rel = 1'b1;
    offset = 6'd4;
    step();
    check_state("abs_over_rel", 100, 10, 1'b1, 1'b0);

    // Positive relative branch alone.
    branch_abs = 1'b0;
    step();
    check_state("rel_p4", 104, 11, 1'b1, 1'b0);
    clear_ctrl();

    // Stall for 3 cycles, with a jump also requested: stall has priority.
    stall = 1'b1;
    branch_abs = 1'b1;
    target = 10'd500;
    for (int i = 1; i <= 3; i++) begin
      step();
      check_state($sformatf("stall%0d", i), 104, 11, 1'b1, 1'b0);
    end
    clear_ctrl();

    // Halt at address 12 with a competing jump: halt wins.
    branch_abs = 1'b1;
    target = 10'd12;
    step();
    check_state("jump12", 12, 12, 1'b1, 1'b0);
    target = 10'd7;
    halt_req = 1'b1;
    step();
    check_state("halt", 12, 12, 1'b0, 1'b1);
    clear_ctrl();
    for (int i = 1; i <= 2; i++) begin
      step();
      check_state($sformatf("halted%0d", i), 12, 12, 1'b0, 1'b1);
    end

    // Restart from HALTED.
    start = 1'b1;
    start_addr = 10'd0;
    step();
    check_state("restart", 0, 0, 1'b1, 1'b0);
    start = 1'b0;

    // Reset mid-run at address 40.
    branch_abs = 1'b1;
    target = 10'd40;
    step();
    check_state("jump40", 40, 1, 1'b1, 1'b0);
    clear_ctrl();
    reset = 1'b0;
    step();
    check_state("reset_midrun", 0, 0, 1'b0, 1'b0);

    // IDLE holds without start.
    reset = 1'b1;
    step();
    step();
    check_state("idle_hold", 0, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
